wshb_arbiter_2m: RTL and testbench

- Two-master, one-slave Wishbone arbiter sharing the SDRAM Wishbone bus in the sys_clk domain.
- Master 0 is the video stream reader (high bandwidth). Master 1 is a generic writer (e.g. pattern/CPU fill).
- Registered round-robin grant. The grant is held for a whole Wishbone cycle (cyc high), then handed over.
- Sits between the requesting masters and the hw_support SDRAM slave port.

---
 rtl/wshb_arbiter_2m.sv | 231 +++++++++++++++++++++++
 tb/tb_wshb_arbiter_2m.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wshb_arbiter_2m.sv
// -----------------------------------------------------------------------------
// wshb_arbiter_2m
//   Two-master, one-slave Wishbone arbiter in front of the SDRAM slave port.
//   Master 0 is the video stream reader and master 1 is a generic writer.
//   The grant is registered and round-robin. Once given, it is held for the
//   whole Wishbone cycle (cyc high), so there is no preemption.
//
//   Optional feature: define WSHB_ARB_TIMEOUT_EN to add a stall watchdog. When
//   a granted master keeps stb high for TIMEOUT cycles with no ack/err/rty, it
//   gets a one-cycle err, slave stb is masked for that cycle, and timeout_evt
//   pulses. Without the macro there is no counter and timeout_evt is tied 0.
//
// Ports
//   sys_clk, sys_rst     : 100 MHz system clock, asynchronous active-high reset
//   wshb_ifs0_*          : slave-side port facing master 0 (video reader)
//   wshb_ifs1_*          : slave-side port facing master 1 (writer)
//   wshb_ifm_*           : master-side port towards the SDRAM slave
//   gnt                  : one-hot registered grant (01 = m0, 10 = m1, 00 = none)
//   timeout_evt          : one-cycle watchdog pulse
// -----------------------------------------------------------------------------
module wshb_arbiter_2m #(
  parameter int TIMEOUT = 1024
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  // port facing master 0
  input  logic        wshb_ifs0_cyc,
  input  logic        wshb_ifs0_stb,
  input  logic        wshb_ifs0_we,
  input  logic [31:0] wshb_ifs0_adr,
  input  logic [31:0] wshb_ifs0_dat_ms,
  input  logic [3:0]  wshb_ifs0_sel,
  input  logic [2:0]  wshb_ifs0_cti,
  input  logic [1:0]  wshb_ifs0_bte,
  output logic [31:0] wshb_ifs0_dat_sm,
  output logic        wshb_ifs0_ack,
  output logic        wshb_ifs0_err,
  output logic        wshb_ifs0_rty,
  // port facing master 1
  input  logic        wshb_ifs1_cyc,
  input  logic        wshb_ifs1_stb,
  input  logic        wshb_ifs1_we,
  input  logic [31:0] wshb_ifs1_adr,
  input  logic [31:0] wshb_ifs1_dat_ms,
  input  logic [3:0]  wshb_ifs1_sel,
  input  logic [2:0]  wshb_ifs1_cti,
  input  logic [1:0]  wshb_ifs1_bte,
  output logic [31:0] wshb_ifs1_dat_sm,
  output logic        wshb_ifs1_ack,
  output logic        wshb_ifs1_err,
  output logic        wshb_ifs1_rty,
  // port to the SDRAM slave
  output logic        wshb_ifm_cyc,
  output logic        wshb_ifm_stb,
  output logic        wshb_ifm_we,
  output logic [31:0] wshb_ifm_adr,
  output logic [31:0] wshb_ifm_dat_ms,
  output logic [3:0]  wshb_ifm_sel,
  output logic [2:0]  wshb_ifm_cti,
  output logic [1:0]  wshb_ifm_bte,
  input  logic [31:0] wshb_ifm_dat_sm,
  input  logic        wshb_ifm_ack,
  input  logic        wshb_ifm_err,
  input  logic        wshb_ifm_rty,
  // status
  output logic [1:0]  gnt,
  output logic        timeout_evt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  // Everything a master drives towards the slave, bundled so the grant mux is
  // a single assignment.
  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat_ms;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
  } wb_req_t;

  state_t  state;
  logic    last;      // master served most recently; the other wins a tie
  wb_req_t req0;
  wb_req_t req1;
  wb_req_t req_g;     // request of the granted master, all zero when idle
  logic    fire;      // watchdog firing this cycle
  logic    rsp_ack;
  logic    rsp_err;
  logic    rsp_rty;

  assign req0 = {wshb_ifs0_cyc, wshb_ifs0_stb, wshb_ifs0_we, wshb_ifs0_adr,
                 wshb_ifs0_dat_ms, wshb_ifs0_sel, wshb_ifs0_cti, wshb_ifs0_bte};
  assign req1 = {wshb_ifs1_cyc, wshb_ifs1_stb, wshb_ifs1_we, wshb_ifs1_adr,
                 wshb_ifs1_dat_ms, wshb_ifs1_sel, wshb_ifs1_cti, wshb_ifs1_bte};

  // ---------------------------------------------------------------------------
  // Arbitration FSM. gnt is updated with the state so it is always a
  // registered copy of it. Leaving a grant when the other master is already
  // waiting goes straight to the other grant: the cycle in which the owner
  // drops cyc is the handover gap, seen by the slave as cyc=0.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= IDLE;
      last  <= 1'b1;
      gnt   <= 2'b00;
    end else begin
      unique case (state)
        IDLE: begin
          if (wshb_ifs0_cyc && (!wshb_ifs1_cyc || last)) begin
            state <= GNT0;
            gnt   <= 2'b01;
          end else if (wshb_ifs1_cyc) begin
            state <= GNT1;
            gnt   <= 2'b10;
          end
        end
        GNT0: begin
          if (!wshb_ifs0_cyc) begin
            last <= 1'b0;
            if (wshb_ifs1_cyc) begin
              state <= GNT1;
              gnt   <= 2'b10;
            end else begin
              state <= IDLE;
              gnt   <= 2'b00;
            end
          end
        end
        GNT1: begin
          if (!wshb_ifs1_cyc) begin
            last <= 1'b1;
            if (wshb_ifs0_cyc) begin
              state <= GNT0;
              gnt   <= 2'b01;
            end else begin
              state <= IDLE;
              gnt   <= 2'b00;
            end
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 2'b00;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Grant mux. Driven from the state register, so an asserted reset clears
  // the slave-side outputs immediately without waiting for a clock edge.
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first; a path that leaves
  // it unassigned would infer a latch.
  always_comb begin
    req_g = '0;
    unique case (state)
      GNT0:    req_g = req0;
      GNT1:    req_g = req1;
      default: req_g = '0;
    endcase
  end

  // stb is qualified by cyc so a master releasing with stb still high never
  // presents a strobe outside a cycle; the watchdog also masks it.
  assign wshb_ifm_cyc    = req_g.cyc;
  assign wshb_ifm_stb    = req_g.stb & req_g.cyc & ~fire;
  assign wshb_ifm_we     = req_g.we;
  assign wshb_ifm_adr    = req_g.adr;
  assign wshb_ifm_dat_ms = req_g.dat_ms;
  assign wshb_ifm_sel    = req_g.sel;
  assign wshb_ifm_cti    = req_g.cti;
  assign wshb_ifm_bte    = req_g.bte;

  // Responses only reach the owner, and only while it still holds cyc: an
  // ack arriving in the release cycle is discarded.
  assign rsp_ack = req_g.cyc & wshb_ifm_ack & ~fire;
  assign rsp_err = req_g.cyc & (wshb_ifm_err | fire);
  assign rsp_rty = req_g.cyc & wshb_ifm_rty & ~fire;

  assign wshb_ifs0_ack = (state == GNT0) & rsp_ack;
  assign wshb_ifs0_err = (state == GNT0) & rsp_err;
  assign wshb_ifs0_rty = (state == GNT0) & rsp_rty;
  assign wshb_ifs1_ack = (state == GNT1) & rsp_ack;
  assign wshb_ifs1_err = (state == GNT1) & rsp_err;
  assign wshb_ifs1_rty = (state == GNT1) & rsp_rty;

  // Read data is broadcast; only the owner receives a qualifying ack.
  assign wshb_ifs0_dat_sm = wshb_ifm_dat_sm;
  assign wshb_ifs1_dat_sm = wshb_ifm_dat_sm;

`ifdef WSHB_ARB_TIMEOUT_EN
  // ---------------------------------------------------------------------------
  // Stall watchdog. The counter holds the number of stb cycles already spent
  // waiting, so it fires on the TIMEOUT-th one. It is held at zero whenever no
  // granted cyc is present, which also clears it on entry to either grant
  // (including a direct GNT0 <-> GNT1 handover, whose gap cycle has cyc=0).
  // ---------------------------------------------------------------------------
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  logic [CNT_W-1:0] wd_cnt;

  assign fire        = req_g.cyc & req_g.stb & (wd_cnt == CNT_W'(TIMEOUT - 1));
  assign timeout_evt = fire;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wd_cnt <= '0;
    end else if (!req_g.cyc || fire || wshb_ifm_ack || wshb_ifm_err || wshb_ifm_rty) begin
      wd_cnt <= '0;
    end else if (req_g.stb) begin
      wd_cnt <= wd_cnt + CNT_W'(1);
    end
  end
`else
  assign fire        = 1'b0;
  assign timeout_evt = 1'b0;
`endif

endmodule

// File: tb/tb_wshb_arbiter_2m.sv
// -----------------------------------------------------------------------------
// tb_wshb_arbiter_2m
//   Self-checking bench for wshb_arbiter_2m. The bench plays both masters and
//   the slave. Inputs change 1 ns after the rising edge; outputs are sampled on
//   the falling edge.
// -----------------------------------------------------------------------------
module tb_wshb_arbiter_2m;

  localparam int TB_TIMEOUT = 16;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        wshb_ifs0_cyc, wshb_ifs0_stb, wshb_ifs0_we;
  logic [31:0] wshb_ifs0_adr, wshb_ifs0_dat_ms, wshb_ifs0_dat_sm;
  logic [3:0]  wshb_ifs0_sel;
  logic [2:0]  wshb_ifs0_cti;
  logic [1:0]  wshb_ifs0_bte;
  logic        wshb_ifs0_ack, wshb_ifs0_err, wshb_ifs0_rty;
  logic        wshb_ifs1_cyc, wshb_ifs1_stb, wshb_ifs1_we;
  logic [31:0] wshb_ifs1_adr, wshb_ifs1_dat_ms, wshb_ifs1_dat_sm;
  logic [3:0]  wshb_ifs1_sel;
  logic [2:0]  wshb_ifs1_cti;
  logic [1:0]  wshb_ifs1_bte;
  logic        wshb_ifs1_ack, wshb_ifs1_err, wshb_ifs1_rty;
  logic        wshb_ifm_cyc, wshb_ifm_stb, wshb_ifm_we;
  logic [31:0] wshb_ifm_adr, wshb_ifm_dat_ms, wshb_ifm_dat_sm;
  logic [3:0]  wshb_ifm_sel;
  logic [2:0]  wshb_ifm_cti;
  logic [1:0]  wshb_ifm_bte;
  logic        wshb_ifm_ack, wshb_ifm_err, wshb_ifm_rty;
  logic [1:0]  gnt;
  logic        timeout_evt;

  int checks   = 0;
  int failures = 0;

  always #5 sys_clk = ~sys_clk;

  wshb_arbiter_2m #(.TIMEOUT(TB_TIMEOUT)) dut (
    .sys_clk          (sys_clk),
    .sys_rst          (sys_rst),
    .wshb_ifs0_cyc    (wshb_ifs0_cyc),
    .wshb_ifs0_stb    (wshb_ifs0_stb),
    .wshb_ifs0_we     (wshb_ifs0_we),
    .wshb_ifs0_adr    (wshb_ifs0_adr),
    .wshb_ifs0_dat_ms (wshb_ifs0_dat_ms),
    .wshb_ifs0_sel    (wshb_ifs0_sel),
    .wshb_ifs0_cti    (wshb_ifs0_cti),
    .wshb_ifs0_bte    (wshb_ifs0_bte),
    .wshb_ifs0_dat_sm (wshb_ifs0_dat_sm),
    .wshb_ifs0_ack    (wshb_ifs0_ack),
    .wshb_ifs0_err    (wshb_ifs0_err),
    .wshb_ifs0_rty    (wshb_ifs0_rty),
    .wshb_ifs1_cyc    (wshb_ifs1_cyc),
    .wshb_ifs1_stb    (wshb_ifs1_stb),
    .wshb_ifs1_we     (wshb_ifs1_we),
    .wshb_ifs1_adr    (wshb_ifs1_adr),
    .wshb_ifs1_dat_ms (wshb_ifs1_dat_ms),
    .wshb_ifs1_sel    (wshb_ifs1_sel),
    .wshb_ifs1_cti    (wshb_ifs1_cti),
    .wshb_ifs1_bte    (wshb_ifs1_bte),
    .wshb_ifs1_dat_sm (wshb_ifs1_dat_sm),
    .wshb_ifs1_ack    (wshb_ifs1_ack),
    .wshb_ifs1_err    (wshb_ifs1_err),
    .wshb_ifs1_rty    (wshb_ifs1_rty),
    .wshb_ifm_cyc     (wshb_ifm_cyc),
    .wshb_ifm_stb     (wshb_ifm_stb),
    .wshb_ifm_we      (wshb_ifm_we),
    .wshb_ifm_adr     (wshb_ifm_adr),
    .wshb_ifm_dat_ms  (wshb_ifm_dat_ms),
    .wshb_ifm_sel     (wshb_ifm_sel),
    .wshb_ifm_cti     (wshb_ifm_cti),
    .wshb_ifm_bte     (wshb_ifm_bte),
    .wshb_ifm_dat_sm  (wshb_ifm_dat_sm),
    .wshb_ifm_ack     (wshb_ifm_ack),
    .wshb_ifm_err     (wshb_ifm_err),
    .wshb_ifm_rty     (wshb_ifm_rty),
    .gnt              (gnt),
    .timeout_evt      (timeout_evt)
  );

  // One cycle of the arbitration table: master/slave inputs, then the
  // outputs expected in that same cycle.
  typedef struct {
    logic        c0, c1, s0, s1, ack;
    logic [1:0]  gnt;
    logic        m_cyc, m_stb;
    logic [31:0] m_adr;
    logic        a0, a1;
  } vec_t;

  vec_t vecs[17];
  int   exp_q[$];   // scoreboard of expected grant order (master index)

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic masters_idle();
    wshb_ifs0_cyc = 0; wshb_ifs0_stb = 0; wshb_ifs0_we = 0;
    wshb_ifs0_dat_ms = 32'h0; wshb_ifs0_sel = 4'h0; wshb_ifs0_cti = 3'd0; wshb_ifs0_bte = 2'd0;
    wshb_ifs1_cyc = 0; wshb_ifs1_stb = 0; wshb_ifs1_we = 0;
    wshb_ifs1_dat_ms = 32'h0; wshb_ifs1_sel = 4'h0; wshb_ifs1_cti = 3'd0; wshb_ifs1_bte = 2'd0;
    wshb_ifs0_adr = 32'h100; wshb_ifs1_adr = 32'h200;
    wshb_ifm_ack = 0; wshb_ifm_err = 0; wshb_ifm_rty = 0;
  endtask

  task automatic do_reset();
    masters_idle();
    sys_rst = 1'b1;
    tick();
    tick();
    sys_rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int acks0, acks1, gnt_bad, done0, done1, beats0, beats1, cyc_budget;
    logic rest0, rest1;
    logic [1:0] prev_gnt;
    int err_bad, evt_bad, stb_bad;

    wshb_ifm_dat_sm = 32'h5A5A_0000;

    // ---- reset state -------------------------------------------------------
    masters_idle();
    sys_rst = 1'b1;
    #3;
    check("rst_gnt", gnt, 2'b00);
    check("rst_m_cyc", wshb_ifm_cyc, 0);
    check("rst_m_stb", wshb_ifm_stb, 0);
    check("rst_m_adr", wshb_ifm_adr, 0);
    check("rst_ack0", wshb_ifs0_ack, 0);
    check("rst_ack1", wshb_ifs1_ack, 0);
    check("rst_evt", timeout_evt, 0);
    tick();
    sys_rst = 1'b0;

    // ---- table: tie after reset, handover gap, discard, simultaneous swap --
    //            c0 c1 s0 s1 ack | gnt   cyc stb adr      a0 a1
    vecs[0]  = '{1, 1, 1, 1, 0,  2'b00, 0,  0,  32'h000, 0, 0};
    vecs[1]  = '{1, 1, 1, 1, 0,  2'b01, 1,  1,  32'h100, 0, 0};
    vecs[2]  = '{1, 1, 1, 1, 1,  2'b01, 1,  1,  32'h100, 1, 0};
    vecs[3]  = '{0, 1, 0, 1, 1,  2'b01, 0,  0,  32'h100, 0, 0};
    vecs[4]  = '{0, 1, 0, 1, 1,  2'b10, 1,  1,  32'h200, 0, 1};
    vecs[5]  = '{0, 0, 0, 0, 0,  2'b10, 0,  0,  32'h200, 0, 0};
    vecs[6]  = '{0, 0, 0, 0, 0,  2'b00, 0,  0,  32'h000, 0, 0};
    vecs[7]  = '{0, 1, 0, 1, 0,  2'b00, 0,  0,  32'h000, 0, 0};
    vecs[8]  = '{1, 1, 1, 1, 0,  2'b10, 1,  1,  32'h200, 0, 0};
    vecs[9]  = '{1, 0, 1, 0, 1,  2'b10, 0,  0,  32'h200, 0, 0};
    vecs[10] = '{1, 0, 1, 0, 1,  2'b01, 1,  1,  32'h100, 1, 0};
    vecs[11] = '{0, 0, 0, 0, 0,  2'b01, 0,  0,  32'h100, 0, 0};
    vecs[12] = '{0, 0, 0, 0, 0,  2'b00, 0,  0,  32'h000, 0, 0};
    vecs[13] = '{1, 1, 1, 1, 0,  2'b00, 0,  0,  32'h000, 0, 0};
    vecs[14] = '{1, 1, 1, 1, 0,  2'b10, 1,  1,  32'h200, 0, 0};
    vecs[15] = '{0, 0, 0, 0, 0,  2'b10, 0,  0,  32'h200, 0, 0};
    vecs[16] = '{0, 0, 0, 0, 0,  2'b00, 0,  0,  32'h000, 0, 0};

    foreach (vecs[i]) begin
      wshb_ifs0_cyc = vecs[i].c0; wshb_ifs0_stb = vecs[i].s0;
      wshb_ifs1_cyc = vecs[i].c1; wshb_ifs1_stb = vecs[i].s1;
      wshb_ifm_ack  = vecs[i].ack;
      @(negedge sys_clk);
      check($sformatf("vec%0d_gnt", i), gnt, vecs[i].gnt);
      check($sformatf("vec%0d_m_cyc", i), wshb_ifm_cyc, vecs[i].m_cyc);
      check($sformatf("vec%0d_m_stb", i), wshb_ifm_stb, vecs[i].m_stb);
      check($sformatf("vec%0d_m_adr", i), wshb_ifm_adr, vecs[i].m_adr);
      check($sformatf("vec%0d_ack0", i), wshb_ifs0_ack, vecs[i].a0);
      check($sformatf("vec%0d_ack1", i), wshb_ifs1_ack, vecs[i].a1);
      tick();
    end

    // ---- single request with full field passthrough ------------------------
    do_reset();
    wshb_ifs0_cyc = 1; wshb_ifs0_stb = 1; wshb_ifs0_we = 1;
    wshb_ifs0_dat_ms = 32'hCAFE_0001; wshb_ifs0_sel = 4'h5;
    wshb_ifs0_cti = 3'd2; wshb_ifs0_bte = 2'd1;
    wshb_ifm_dat_sm = 32'hBEEF_1234;
    @(negedge sys_clk);
    check("single_gnt_req_cycle", gnt, 2'b00);
    tick();
    @(negedge sys_clk);
    check("single_gnt", gnt, 2'b01);
    check("single_m_cyc", wshb_ifm_cyc, 1);
    check("single_m_adr", wshb_ifm_adr, 32'h100);
    check("single_m_we", wshb_ifm_we, 1);
    check("single_m_dat", wshb_ifm_dat_ms, 32'hCAFE_0001);
    check("single_m_sel", wshb_ifm_sel, 4'h5);
    check("single_m_cti", wshb_ifm_cti, 3'd2);
    check("single_m_bte", wshb_ifm_bte, 2'd1);
    check("single_dat_sm0", wshb_ifs0_dat_sm, 32'hBEEF_1234);
    check("single_dat_sm1", wshb_ifs1_dat_sm, 32'hBEEF_1234);
    acks0 = int'(wshb_ifs0_ack);
    acks1 = int'(wshb_ifs1_ack);
    for (int j = 1; j <= 3; j++) begin
      tick();
      wshb_ifm_ack = (j == 3);
      @(negedge sys_clk);
      acks0 += int'(wshb_ifs0_ack);
      acks1 += int'(wshb_ifs1_ack);
    end
    tick();
    wshb_ifm_ack = 0; wshb_ifs0_cyc = 0; wshb_ifs0_stb = 0;
    @(negedge sys_clk);
    acks0 += int'(wshb_ifs0_ack);
    acks1 += int'(wshb_ifs1_ack);
    tick();
    @(negedge sys_clk);
    check("single_ack0_count", acks0, 1);
    check("single_ack1_count", acks1, 0);
    check("single_release_gnt", gnt, 2'b00);

    // ---- round-robin fairness with scoreboard ------------------------------
    do_reset();
    exp_q.delete();
    exp_q.push_back(0);   // last=1 after reset, so m0 wins the first tie
    done0 = 0; done1 = 0; beats0 = 0; beats1 = 0;
    rest0 = 0; rest1 = 0; prev_gnt = 2'b00; cyc_budget = 0;
    while (done0 + done1 < 20 && cyc_budget < 2000) begin
      wshb_ifs0_cyc = !rest0; wshb_ifs0_stb = !rest0;
      wshb_ifs1_cyc = !rest1; wshb_ifs1_stb = !rest1;
      rest0 = 0; rest1 = 0;
      #1;
      wshb_ifm_ack = wshb_ifm_stb;   // slave acks every strobe
      @(negedge sys_clk);
      if (gnt != prev_gnt && gnt != 2'b00) begin
        if (exp_q.size() == 0) begin
          check("rr_queue_underflow", 1, 0);
        end else begin
          int exp_m;
          exp_m = exp_q.pop_front();
          check($sformatf("rr_grant_%0d", done0 + done1), gnt, (exp_m == 0) ? 2'b01 : 2'b10);
          exp_q.push_back(1 - exp_m);
        end
      end
      prev_gnt = gnt;
      if (wshb_ifs0_ack) begin
        beats0++;
        if (beats0 == 4) begin beats0 = 0; done0++; rest0 = 1; end
      end
      if (wshb_ifs1_ack) begin
        beats1++;
        if (beats1 == 4) begin beats1 = 0; done1++; rest1 = 1; end
      end
      cyc_budget++;
      tick();
    end
    check("rr_budget_ok", (cyc_budget < 2000), 1);
    check("rr_done0", done0, 10);
    check("rr_done1", done1, 10);
    masters_idle();
    tick(); tick(); tick();

    // ---- no preemption -----------------------------------------------------
    do_reset();
    gnt_bad = 0; acks0 = 0; acks1 = 0;
    wshb_ifs1_cyc = 1; wshb_ifs1_stb = 1;
    for (int i = 0; i < 50; i++) begin
      if (i == 5) begin wshb_ifs0_cyc = 1; wshb_ifs0_stb = 1; end
      wshb_ifm_ack = (i % 6 == 3);
      @(negedge sys_clk);
      if (i >= 1 && gnt != 2'b10) gnt_bad++;
      acks0 += int'(wshb_ifs0_ack);
      acks1 += int'(wshb_ifs1_ack);
      tick();
    end
    wshb_ifm_ack = 0; wshb_ifs1_cyc = 0; wshb_ifs1_stb = 0;
    @(negedge sys_clk);
    check("nopre_release_cycle_gnt", gnt, 2'b10);
    tick();
    @(negedge sys_clk);
    check("nopre_gnt_held", gnt_bad, 0);
    check("nopre_ack1_count", acks1, 8);
    check("nopre_ack0_count", acks0, 0);
    check("nopre_gnt_m0", gnt, 2'b01);
    check("nopre_m_adr", wshb_ifm_adr, 32'h100);
    masters_idle();
    tick(); tick();

    // ---- reset mid-burst ---------------------------------------------------
    do_reset();
    wshb_ifs0_cyc = 1; wshb_ifs0_stb = 1;
    tick();                       // IDLE -> GNT0 at next edge
    wshb_ifm_ack = 1;
    tick();                       // GNT0, ack 1
    tick();                       // GNT0, ack 2
    wshb_ifm_ack = 0;
    #2;
    check("midrst_pre_gnt", gnt, 2'b01);
    check("midrst_pre_m_cyc", wshb_ifm_cyc, 1);
    sys_rst = 1'b1;
    #1;
    check("midrst_m_cyc", wshb_ifm_cyc, 0);
    check("midrst_m_stb", wshb_ifm_stb, 0);
    check("midrst_gnt", gnt, 2'b00);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    wshb_ifs1_cyc = 1; wshb_ifs1_stb = 1;
    tick();
    @(negedge sys_clk);
    check("midrst_regrant_m0", gnt, 2'b01);
    masters_idle();
    tick(); tick(); tick();

    // ---- watchdog ----------------------------------------------------------
    do_reset();
    err_bad = 0; evt_bad = 0; stb_bad = 0;
    wshb_ifs1_cyc = 1; wshb_ifs1_stb = 1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      @(negedge sys_clk);
`ifdef WSHB_ARB_TIMEOUT_EN
      if (k == TB_TIMEOUT) begin
        check("wd_err1", wshb_ifs1_err, 1);
        check("wd_ack1", wshb_ifs1_ack, 0);
        check("wd_evt", timeout_evt, 1);
        check("wd_m_stb", wshb_ifm_stb, 0);
      end else begin
        if (wshb_ifs1_err) err_bad++;
        if (timeout_evt) evt_bad++;
        if (!wshb_ifm_stb) stb_bad++;
      end
`else
      if (wshb_ifs1_err) err_bad++;
      if (timeout_evt) evt_bad++;
      if (!wshb_ifm_stb) stb_bad++;
`endif
    end
    check("wd_no_spurious_err", err_bad, 0);
    check("wd_no_spurious_evt", evt_bad, 0);
    check("wd_stb_forwarded", stb_bad, 0);
    check("wd_grant_held", gnt, 2'b10);
    masters_idle();
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
